// File: rtl/xcorr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xcorr_pkg
// Description : Shared helpers for the streaming cross-correlator: constant
//               clog2, result/lag width derivation and the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package xcorr_pkg;

    // Ceiling log2 usable in parameter expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Accumulator width: a full 2W-bit product summed N times cannot grow by
    // more than clog2(N) bits.
    function automatic int acc_width(input int w, input int n);
        return 2 * w + clog2(n);
    endfunction

    // Signed lag field wide enough for -lag..+lag.
    function automatic int lag_width(input int lag);
        return clog2(lag) + 2;
    endfunction

    // Number of pipeline-drain cycles between the last sample and unload.
    localparam int c_FLUSH_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCUM  = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_UNLOAD = 3'd3,
        ST_DONE   = 3'd4
    } xcorr_state_e;

endpackage : xcorr_pkg
`default_nettype wire

// File: rtl/xcorr_mac_lane.sv
`default_nettype none
// ============================================================================
// Module      : xcorr_mac_lane
// Description : One lag lane of the correlator. Registers a*b, then adds the
//               sign-extended product into a wrapping accumulator.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous clear of product stage and accumulator
//   en        : operands valid (one accepted sample)
//   a, b      : signed W-bit operands
//   acc       : signed ACC_W-bit running sum
// Revision    : 1.0 - initial release
// ============================================================================
module xcorr_mac_lane #(
    parameter int W     = 16,
    parameter int ACC_W = 42
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [W-1:0]     a,
    input  logic signed [W-1:0]     b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*W-1:0]   w_a_ext;
    logic signed [2*W-1:0]   w_b_ext;
    logic signed [2*W-1:0]   r_prod;
    logic                    r_prod_vld;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] r_acc;

    assign w_a_ext    = {{W{a[W-1]}}, a};
    assign w_b_ext    = {{W{b[W-1]}}, b};
    assign w_prod_ext = {{(ACC_W-2*W){r_prod[2*W-1]}}, r_prod};

    // A clear also kills a product still in flight, so a restart mid-frame
    // cannot leak one old sample into the new frame.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_prod_vld <= en;
            if (en) begin
                r_prod <= w_a_ext * w_b_ext;
            end
            if (r_prod_vld) begin
                r_acc <= r_acc + w_prod_ext;
            end
        end
    end

    assign acc = r_acc;

endmodule : xcorr_mac_lane
`default_nettype wire

// File: rtl/xcorr_stream_peak.sv
`default_nettype none
// ============================================================================
// Module      : xcorr_stream_peak
// Description : Streaming cross-correlator r[d] = sum_n x[n+d]*y[n] for
//               d = -LAG..+LAG over an N-sample frame, with serial result
//               unload and peak (signed or magnitude) search.
//   clk, rst         : clock, synchronous active-high reset
//   start            : begin/restart a frame (honoured in IDLE or ACCUM)
//   in_valid         : sample pair valid
//   series_x/_y      : signed W-bit samples
//   abs_mode         : peak criterion, latched at start (1 = max |r|)
//   busy             : high in ACCUM/FLUSH/UNLOAD
//   result/res_lag   : r[d] and d, one per cycle while res_valid
//   done             : one-cycle pulse, peak_lag/peak_value updated
// Revision    : 1.0 - initial release
// ============================================================================
module xcorr_stream_peak
    import xcorr_pkg::*;
#(
    parameter int W     = 16,
    parameter int N     = 1024,
    parameter int LAG   = 10,
    parameter int ACC_W = acc_width(W, N),
    parameter int LAG_W = lag_width(LAG)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic signed [W-1:0]     series_x,
    input  logic signed [W-1:0]     series_y,
    input  logic                    abs_mode,
    output logic                    busy,
    output logic signed [ACC_W-1:0] result,
    output logic                    res_valid,
    output logic signed [LAG_W-1:0] res_lag,
    output logic                    done,
    output logic signed [LAG_W-1:0] peak_lag,
    output logic signed [ACC_W-1:0] peak_value
);

    localparam int c_NL    = 2 * LAG + 1;
    localparam int c_CNT_W = clog2(N + 1);
    localparam int c_IDX_W = (clog2(c_NL) < 1) ? 1 : clog2(c_NL);

    xcorr_state_e            r_state;
    xcorr_state_e            w_next_state;

    logic                    w_accept;
    logic                    w_clear;
    logic                    w_last_sample;
    logic                    w_last_idx;
    logic                    w_flush_end;

    logic [c_CNT_W-1:0]      r_cnt;
    logic [1:0]              r_flush_cnt;
    logic [c_IDX_W-1:0]      r_idx;
    logic                    r_abs_mode;

    logic signed [W-1:0]     r_xdl [1:LAG];
    logic signed [W-1:0]     r_ydl [1:LAG];

    logic signed [W-1:0]     w_a   [c_NL];
    logic signed [W-1:0]     w_b   [c_NL];
    logic signed [ACC_W-1:0] w_acc [c_NL];

    logic signed [ACC_W-1:0] w_cur_val;
    logic signed [LAG_W-1:0] w_cur_lag;
    logic                    w_better;
    logic signed [ACC_W-1:0] r_best_val;
    logic signed [LAG_W-1:0] r_best_lag;
    logic signed [ACC_W-1:0] r_peak_value;
    logic signed [LAG_W-1:0] r_peak_lag;

    // Unsigned magnitude; the most negative value maps to 2^(ACC_W-1).
    function automatic logic [ACC_W-1:0] mag(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-1:0] u;
        u = v;
        return v[ACC_W-1] ? (~u + 1'b1) : u;
    endfunction

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    assign w_clear       = start && (r_state == ST_IDLE || r_state == ST_ACCUM);
    assign w_accept      = (r_state == ST_ACCUM) && in_valid && !start;
    assign w_last_sample = (r_cnt == c_CNT_W'(N - 1));
    assign w_last_idx    = (r_idx == c_IDX_W'(c_NL - 1));
    assign w_flush_end   = (r_flush_cnt == 2'(c_FLUSH_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next_state = ST_ACCUM;
            ST_ACCUM:  if (w_accept && w_last_sample) w_next_state = ST_FLUSH;
            ST_FLUSH:  if (w_flush_end) w_next_state = ST_UNLOAD;
            ST_UNLOAD: if (w_last_idx) w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Sample counter, mode latch, drain/unload counters and delay lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_abs_mode  <= 1'b0;
            r_flush_cnt <= '0;
            r_idx       <= '0;
            for (int m = 1; m <= LAG; m++) begin
                r_xdl[m] <= '0;
                r_ydl[m] <= '0;
            end
        end else begin
            if (w_clear) begin
                r_cnt      <= '0;
                r_abs_mode <= abs_mode;
                for (int m = 1; m <= LAG; m++) begin
                    r_xdl[m] <= '0;
                    r_ydl[m] <= '0;
                end
            end else if (w_accept) begin
                r_cnt    <= r_cnt + 1'b1;
                r_xdl[1] <= series_x;
                r_ydl[1] <= series_y;
                for (int m = 2; m <= LAG; m++) begin
                    r_xdl[m] <= r_xdl[m-1];
                    r_ydl[m] <= r_ydl[m-1];
                end
            end
            r_flush_cnt <= (r_state == ST_FLUSH)  ? r_flush_cnt + 1'b1 : '0;
            r_idx       <= (r_state == ST_UNLOAD) ? r_idx + 1'b1       : '0;
        end
    end

    // ------------------------------------------------------------------
    // MAC lanes: lane k holds r[k-LAG]. Non-negative lags pair the current
    // x with delayed y; negative lags pair the current y with delayed x.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < c_NL; k++) begin : g_lane
        if (k == LAG) begin : g_lag_zero
            assign w_a[k] = series_x;
            assign w_b[k] = series_y;
        end else if (k > LAG) begin : g_lag_pos
            assign w_a[k] = series_x;
            assign w_b[k] = r_ydl[k-LAG];
        end else begin : g_lag_neg
            assign w_a[k] = series_y;
            assign w_b[k] = r_xdl[LAG-k];
        end

        xcorr_mac_lane #(
            .W     (W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (w_clear),
            .en    (w_accept),
            .a     (w_a[k]),
            .b     (w_b[k]),
            .acc   (w_acc[k])
        );
    end

    // ------------------------------------------------------------------
    // Unload mux and peak tracker
    // ------------------------------------------------------------------
    assign w_cur_val = w_acc[r_idx];
    assign w_cur_lag = LAG_W'(r_idx) - LAG_W'(LAG);

    // The first result always seeds the tracker; afterwards only a strictly
    // better value replaces it, so ties keep the most negative lag.
    assign w_better = (r_idx == '0) ||
                      (r_abs_mode ? (mag(w_cur_val) > mag(r_best_val))
                                  : (w_cur_val > r_best_val));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_best_val   <= '0;
            r_best_lag   <= '0;
            r_peak_value <= '0;
            r_peak_lag   <= '0;
        end else if (r_state == ST_UNLOAD) begin
            if (w_better) begin
                r_best_val <= w_cur_val;
                r_best_lag <= w_cur_lag;
            end
            if (w_last_idx) begin
                r_peak_value <= w_better ? w_cur_val : r_best_val;
                r_peak_lag   <= w_better ? w_cur_lag : r_best_lag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy       = (r_state == ST_ACCUM) || (r_state == ST_FLUSH) ||
                        (r_state == ST_UNLOAD);
    assign res_valid  = (r_state == ST_UNLOAD);
    assign result     = res_valid ? w_cur_val : '0;
    assign res_lag    = res_valid ? w_cur_lag : '0;
    assign done       = (r_state == ST_DONE);
    assign peak_lag   = r_peak_lag;
    assign peak_value = r_peak_value;

endmodule : xcorr_stream_peak
`default_nettype wire

// File: tb/tb_xcorr_stream_peak.sv
`default_nettype none
// ============================================================================
// Module      : tb_xcorr_stream_peak
// Description : Scoreboard bench for xcorr_stream_peak. The stimulus side
//               computes every r[d] and the peak directly from the frame
//               arrays (sum formula, zero padding) and queues them; a
//               negedge monitor pops and compares whenever the DUT presents
//               res_valid or done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xcorr_stream_peak;

    localparam int W     = 16;
    localparam int N     = 1024;
    localparam int LAG   = 10;
    localparam int ACC_W = 42;
    localparam int LAG_W = 6;
    localparam int NL    = 2 * LAG + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                in_valid;
    logic signed [W-1:0] series_x;
    logic signed [W-1:0] series_y;
    logic                abs_mode;
    logic                busy;
    logic [ACC_W-1:0]    result;
    logic                res_valid;
    logic [LAG_W-1:0]    res_lag;
    logic                done;
    logic [LAG_W-1:0]    peak_lag;
    logic [ACC_W-1:0]    peak_value;

    xcorr_stream_peak #(
        .W   (W),
        .N   (N),
        .LAG (LAG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .series_x   (series_x),
        .series_y   (series_y),
        .abs_mode   (abs_mode),
        .busy       (busy),
        .result     (result),
        .res_valid  (res_valid),
        .res_lag    (res_lag),
        .done       (done),
        .peak_lag   (peak_lag),
        .peak_value (peak_value)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint val;
        int     lag;
    } res_t;

    res_t exp_q[$];
    res_t peak_q[$];

    int  n_checks     = 0;
    int  n_fail       = 0;
    int  last_acc_cyc = 0;
    int  res_in_frame = 0;
    int  done_cnt     = 0;
    bit  seen_first   = 0;

    logic signed [W-1:0] fx [N];
    logic signed [W-1:0] fy [N];

    task automatic check_val(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sx(input logic [ACC_W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic int slag(input logic [LAG_W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: direct correlation sum with out-of-frame samples as zero.
    task automatic push_expected(input bit absm);
        longint r;
        res_t   e;
        res_t   best;
        best.val = 0;
        best.lag = 0;
        for (int d = -LAG; d <= LAG; d++) begin
            r = 0;
            for (int n = 0; n < N; n++) begin
                if (n + d >= 0 && n + d < N) begin
                    r += longint'(fx[n+d]) * longint'(fy[n]);
                end
            end
            e.val = r;
            e.lag = d;
            exp_q.push_back(e);
            if (d == -LAG) begin
                best = e;
            end else if (absm ? (labs(r) > labs(best.val)) : (r > best.val)) begin
                best = e;
            end
        end
        peak_q.push_back(best);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_busy"},       longint'(busy),      0);
        check_val({tag, "_res_valid"},  longint'(res_valid), 0);
        check_val({tag, "_result"},     sx(result),          0);
        check_val({tag, "_res_lag"},    slag(res_lag),       0);
        check_val({tag, "_done"},       longint'(done),      0);
        check_val({tag, "_peak_lag"},   slag(peak_lag),      0);
        check_val({tag, "_peak_value"}, sx(peak_value),      0);
    endtask

    task automatic pulse_start(input bit absm);
        start    = 1'b1;
        in_valid = 1'b1;
        series_x = W'($urandom);
        series_y = W'($urandom);
        abs_mode = absm;
        @(posedge clk); #1;
        start    = 1'b0;
        abs_mode = ~absm;
        check_val("busy_after_start", longint'(busy), 1);
    endtask

    task automatic wait_done();
        int c0;
        c0 = done_cnt;
        for (int i = 0; i < 300 && done_cnt == c0; i++) @(posedge clk);
        check_val("done_count", done_cnt - c0, 1);
        #1;
    endtask

    // Starts a frame, feeds fx/fy with random idle gaps, then either waits
    // for done or resets the DUT after the fifth result.
    task automatic run_frame(input bit absm, input int gap_pct, input bit rst_mid);
        push_expected(absm);
        pulse_start(absm);
        for (int n = 0; n < N; n++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                series_x = W'($urandom);
                series_y = W'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            series_x = fx[n];
            series_y = fy[n];
            if (n == N - 1) last_acc_cyc = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (rst_mid) begin
            for (int i = 0; i < 100 && res_in_frame < 5; i++) @(posedge clk);
            check_val("rst_wait_res5", longint'(res_in_frame >= 5), 1);
            #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check_zero_outputs("after_mid_rst");
            repeat (40) @(posedge clk);
            #1;
        end else begin
            wait_done();
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        res_t e;
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_res_valid: res_lag=%0d result=%0d, expected no result",
                         slag(res_lag), sx(result));
            end else begin
                e = exp_q.pop_front();
                check_val("result", sx(result), e.val);
                check_val("res_lag", slag(res_lag), e.lag);
                if (!seen_first) begin
                    check_val("first_res_latency", cyc - last_acc_cyc, 3);
                    seen_first = 1;
                end
                res_in_frame++;
            end
        end
        if (done) begin
            if (peak_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: peak_lag=%0d, expected no done", slag(peak_lag));
            end else begin
                e = peak_q.pop_front();
                check_val("peak_value", sx(peak_value), e.val);
                check_val("peak_lag", slag(peak_lag), e.lag);
                check_val("results_per_frame", res_in_frame, NL);
            end
            res_in_frame = 0;
            seen_first   = 0;
            done_cnt++;
        end
        if (rst) begin
            exp_q.delete();
            peak_q.delete();
            res_in_frame = 0;
            seen_first   = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        abs_mode = 1'b0;
        series_x = '0;
        series_y = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Impulse pair: r[3] = -700, everything else zero.
        for (int n = 0; n < N; n++) begin
            fx[n] = '0;
            fy[n] = '0;
        end
        fy[5] = W'(100);
        fx[8] = W'(-7);
        run_frame(1'b1, 0, 1'b0);
        run_frame(1'b0, 0, 1'b0);

        // Constant ones: r[d] = N - |d|.
        for (int n = 0; n < N; n++) begin
            fx[n] = W'(1);
            fy[n] = W'(1);
        end
        run_frame(1'b0, 0, 1'b0);

        // Full-scale negative samples.
        for (int n = 0; n < N; n++) begin
            fx[n] = W'(32'h8000);
            fy[n] = W'(32'h8000);
        end
        run_frame(1'b1, 0, 1'b0);

        // Restart mid-frame after 500 random samples, then constant ones.
        pulse_start(1'b1);
        for (int n = 0; n < 500; n++) begin
            in_valid = 1'b1;
            series_x = W'($urandom);
            series_y = W'($urandom);
            @(posedge clk); #1;
        end
        for (int n = 0; n < N; n++) begin
            fx[n] = W'(1);
            fy[n] = W'(1);
        end
        run_frame(1'b0, 0, 1'b0);

        // Random data with idle gaps, both peak criteria.
        for (int f = 0; f < 2; f++) begin
            for (int n = 0; n < N; n++) begin
                fx[n] = W'($urandom);
                fy[n] = W'($urandom);
            end
            run_frame(f[0], 30, 1'b0);
        end

        // Reset during unload, then a clean frame afterwards.
        for (int n = 0; n < N; n++) begin
            fx[n] = W'($urandom);
            fy[n] = W'($urandom);
        end
        run_frame(1'b1, 20, 1'b1);
        for (int n = 0; n < N; n++) begin
            fx[n] = W'($urandom_range(200)) - W'(100);
            fy[n] = W'($urandom);
        end
        run_frame(1'b0, 30, 1'b0);

        repeat (10) @(posedge clk);
        #1;
        check_val("scoreboard_drained", exp_q.size() + peak_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_xcorr_stream_peak
`default_nettype wire
